// File: rtl/axi4_wdata_fifo_drain.sv
// axi4_wdata_fifo_drain
// Read-side consumer of the 37-bit AXI4 write-data CDC FIFO. Pops FWFT entries
// {last, strb, data}, pairs them with burst-length commands and presents them on
// an AXI4 W channel through a 2-entry registered output buffer. FIFO 'last' flags
// are checked against the command length and mismatches latch into last_err_o.
//
// state | meaning
// IDLE  | waiting for a burst command, cmd_ready_o=1, no pops
// DATA  | popping beats of the current burst until beat_cnt reaches len_q
module axi4_wdata_fifo_drain #(
  parameter bit FORCE_LAST = 1'b0,
  parameter bit CHECK_LAST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [7:0]  cmd_len_i,
  output logic        cmd_ready_o,
  input  logic        fifo_empty_i,
  input  logic [36:0] fifo_data_i,
  output logic        fifo_pop_o,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  output logic        burst_done_o,
  output logic        last_err_o,
  input  logic        err_clr_i
);

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [36:0] obuf0_q, obuf0_d;
  logic [36:0] obuf1_q, obuf1_d;
  logic [1:0]  obuf_cnt_q, obuf_cnt_d;
  logic        last_err_q, last_err_d;

  logic        pop;
  logic        exp_last;
  logic        w_hs;
  logic        push_last;
  logic [36:0] push_ent;

  // pop only while a burst is open, data is present and the output buffer has room
  assign pop       = (state_q == DATA) & ~fifo_empty_i & (obuf_cnt_q != 2'd2);
  assign exp_last  = (beat_cnt_q == len_q);
  assign push_last = FORCE_LAST ? exp_last : fifo_data_i[36];
  assign push_ent  = {push_last, fifo_data_i[35:0]};
  assign w_hs      = axi_wvalid_o & axi_wready_i;

  assign cmd_ready_o  = (state_q == IDLE);
  assign fifo_pop_o   = pop;
  assign axi_wvalid_o = (obuf_cnt_q != 2'd0);
  assign axi_wdata_o  = obuf0_q[31:0];
  assign axi_wstrb_o  = obuf0_q[35:32];
  assign axi_wlast_o  = obuf0_q[36];
  assign burst_done_o = w_hs & axi_wlast_o;
  assign last_err_o   = last_err_q;

  // next-state: command accept in IDLE, beat counting and burst close in DATA
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          len_d      = cmd_len_i;
          beat_cnt_d = 8'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (pop) begin
          // saturate: a 256-beat burst closes on beat_cnt==255 anyway
          if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
          if (exp_last) state_d = IDLE;
        end
      end
    endcase
  end

  // output buffer: obuf0 is always the head; obuf1 only holds a second beat
  always_comb begin
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;
    case (obuf_cnt_q)
      2'd0: begin
        if (pop) begin
          obuf0_d    = push_ent;
          obuf_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && w_hs) begin
          obuf0_d = push_ent;
        end else if (pop) begin
          obuf1_d    = push_ent;
          obuf_cnt_d = 2'd2;
        end else if (w_hs) begin
          obuf_cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (w_hs) begin
          obuf0_d    = obuf1_q;
          obuf_cnt_d = 2'd1;
        end
      end
      default: obuf_cnt_d = 2'd0;
    endcase
  end

  // sticky last-flag mismatch; a new mismatch wins over a clear in the same cycle
  always_comb begin
    last_err_d = last_err_q;
    if (CHECK_LAST && pop && (fifo_data_i[36] != exp_last)) begin
      last_err_d = 1'b1;
    end else if (err_clr_i) begin
      last_err_d = 1'b0;
    end
  end

  // register bank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      beat_cnt_q <= 8'd0;
      obuf0_q    <= 37'd0;
      obuf1_q    <= 37'd0;
      obuf_cnt_q <= 2'd0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      obuf_cnt_q <= obuf_cnt_d;
      last_err_q <= last_err_d;
    end
  end

endmodule
